// File: rtl/mux_arb_rr_4_to_1.sv
// Round-robin arbiter over four requesters feeding a shared 4:1 mux,
// with a one-entry valid/ready output buffer.
module mux_arb_rr_4_to_1 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [3:0]                 i_req,
    input  logic [3:0][DATA_WIDTH-1:0] i_val,
    output logic [3:0]                 o_gnt,
    output logic [1:0]                 o_key,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WIDTH-1:0]      o_val
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            last_q, last_d;
    logic [1:0]            key_q, key_d;
    logic [3:0]            gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;

    logic       can_load;
    logic       found;
    logic       load;
    logic [1:0] win;
    logic [1:0] idx;

    // Search starts just past the last winner; k=4 wraps back to it.
    always_comb begin
        can_load = (state_q == IDLE) || i_ready;
        found    = 1'b0;
        win      = last_q;
        idx      = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        load = can_load && found;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if ((state_q == FULL) && i_ready) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        val_d  = val_q;
        key_d  = key_q;
        last_d = last_q;
        gnt_d  = 4'b0000;
        if (load) begin
            val_d  = i_val[win];
            key_d  = win;
            last_d = win;
            gnt_d  = 4'b0001 << win;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            key_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            key_q   <= key_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        o_valid = (state_q == FULL);
        o_gnt   = gnt_q;
        o_key   = key_q;
        o_val   = val_q;
    end

endmodule

// File: tb/tb_mux_arb_rr_4_to_1.sv
// Bench for mux_arb_rr_4_to_1: directed vector table, hand sequences,
// then random traffic against a behavioural round-robin model.
module tb_mux_arb_rr_4_to_1;

    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [3:0][DW-1:0] vals;
    logic               ready;
    logic [3:0]         gnt;
    logic [1:0]         key;
    logic               valid;
    logic [DW-1:0]      val;

    int n_tests = 0;
    int n_fail  = 0;

    mux_arb_rr_4_to_1 #(.DATA_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_val   (vals),
        .o_gnt   (gnt),
        .o_key   (key),
        .o_valid (valid),
        .i_ready (ready),
        .o_val   (val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic [DW-1:0] vbase;
        logic          ready;
        logic [3:0]    e_gnt;
        logic [1:0]    e_key;
        logic          e_valid;
        logic [DW-1:0] e_val;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] q, int vb, logic rd,
                                logic [3:0] g, logic [1:0] k, logic v, int d);
        vec_t t;
        t.rst = r; t.req = q; t.vbase = DW'(vb); t.ready = rd;
        t.e_gnt = g; t.e_key = k; t.e_valid = v; t.e_val = DW'(d);
        return t;
    endfunction

    task automatic check(string name, logic [3:0] g, logic [1:0] k,
                         logic v, logic [DW-1:0] d);
        n_tests++;
        if (gnt !== g || key !== k || valid !== v || val !== d) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b key=%0d valid=%b val=%h, want gnt=%b key=%0d valid=%b val=%h",
                     name, gnt, key, valid, val, g, k, v, d);
        end
    endtask

    // Apply inputs for one cycle, then sample just after the edge.
    task automatic cyc(logic r, logic [3:0] q, int vb, logic rd);
        rst = r; req = q; ready = rd;
        for (int n = 0; n < 4; n++) vals[n] = DW'(vb + n);
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state
    logic          m_full;
    logic [DW-1:0] m_val;
    int            m_key, m_last;
    logic [3:0]    m_gnt;

    task automatic model_step();
        int w;
        if (rst) begin
            m_full = 0; m_val = '0; m_key = 0; m_gnt = '0; m_last = 3;
            return;
        end
        w = -1;
        if (!m_full || ready) begin
            for (int k = 1; k <= 4; k++)
                if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
        if (w >= 0) begin
            m_val = vals[w]; m_key = w; m_last = w;
            m_gnt = 4'(1 << w); m_full = 1;
        end else begin
            m_gnt = '0;
            if (m_full && ready) m_full = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0; vals = '0;

        // reset with all requesting, then first grant to requester 0
        vecs.push_back(mk(1, 4'hF, 1, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(1, 4'hF, 1, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hF, 1, 1, 4'h1, 0, 1, 1));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0, 0, 1));
        // single requester 2
        vecs.push_back(mk(0, 4'h4, 1, 1, 4'h4, 2, 1, 3));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'h0, 2, 0, 3));
        // rotation from fresh reset
        vecs.push_back(mk(1, 4'h0, 1, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hF, 1, 1, 4'h1, 0, 1, 1));
        vecs.push_back(mk(0, 4'hF, 1, 1, 4'h2, 1, 1, 2));
        vecs.push_back(mk(0, 4'hF, 1, 1, 4'h4, 2, 1, 3));
        vecs.push_back(mk(0, 4'hF, 1, 1, 4'h8, 3, 1, 4));
        vecs.push_back(mk(0, 4'hF, 1, 1, 4'h1, 0, 1, 1));
        vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 1));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0, 0, 1));
        // backpressure with word 2 buffered
        vecs.push_back(mk(1, 4'h0, 1, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h2, 1, 1, 4'h2, 1, 1, 2));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 4'h9, 1, 0, 4'h0, 1, 1, 2));
        vecs.push_back(mk(0, 4'h9, 1, 1, 4'h8, 3, 1, 4));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].req, int'(vecs[i].vbase), vecs[i].ready);
            check($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_key,
                  vecs[i].e_valid, vecs[i].e_val);
        end

        // mid-transaction reset drops the stalled word
        cyc(1, 4'h9, 1, 0);
        check("midrst", 4'h0, 0, 0, 0);
        cyc(0, 4'h9, 1, 0);
        check("midrst_first", 4'h1, 0, 1, 1);

        // fairness: requester 1 gets in between requester 0 loads
        cyc(0, 4'h3, 1, 1);
        check("fair_r1", 4'h2, 1, 1, 2);
        cyc(0, 4'h1, 1, 1);
        check("fair_r0", 4'h1, 0, 1, 1);
        cyc(0, 4'h1, 1, 1);
        check("fair_r0_again", 4'h1, 0, 1, 1);

        // random traffic against the model
        rst = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        check("rnd_reset", m_gnt, 2'(m_key), m_full, m_val);
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 39) == 0);
            req   = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 4; n++) vals[n] = $urandom;
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d", c), m_gnt, 2'(m_key), m_full, m_val);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
